uart_serial_port: RTL

UART_SERIAL_PORT -- requirements
Module: uart_serial_port

---
 rtl/uart_serial_port.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_serial_port.sv
// Memory-mapped 8N1 UART: one-byte TX holding register, one-byte RX buffer,
// status register, and an interrupt raised when a received byte equals 0x03.
module uart_serial_port #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cs,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wr_val,
  input  logic [3:0]  bus_bytesel,
  output logic        bus_ack,
  output logic [31:0] bus_data,
  output logic        irq,      // named irq because 'int' is a reserved word
  input  logic        intack,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic unused_bus_bits;
  assign unused_bus_bits = &{1'b0, bus_addr[31:4], bus_wr_val[31:8]};

  // Bus decode
  logic       wr;
  logic       rd;
  logic       first;
  logic [3:0] reg_sel;
  logic       tx_wr;
  logic       irq_wr_clr;
  logic       data_rd_clr;
  logic       stat_rd_clr;

  assign reg_sel     = bus_addr[3:0];
  assign wr          = cs && (bus_bytesel == 4'b0001);
  assign rd          = cs && (bus_bytesel != 4'b0001);
  assign first       = cs && !bus_ack;  // bus_ack is cs one cycle late
  assign tx_wr       = wr && (reg_sel == 4'h0);
  assign irq_wr_clr  = wr && (reg_sel == 4'h8);
  assign data_rd_clr = rd && first && (reg_sel == 4'h0);
  assign stat_rd_clr = rd && first && (reg_sel == 4'h4);

  // TX state
  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic          tx_full;
  logic [7:0]    tx_hold;
  logic [7:0]    tx_shift;
  logic          tx_load;

  // RX state
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_buf;
  logic          rx_valid;
  logic          rx_overrun;
  logic          rx_framing;

  logic rx_sample;
  logic rx_clr;
  logic rx_busy;
  logic rx_store;
  logic rx_ovr_set;
  logic rx_fe_set;
  logic irq_set;
  logic irq_clr;

  // Read mux
  logic [31:0] rdata;

  always_comb begin
    // NOTE: default assignment first so every path drives rdata and no latch is inferred.
    rdata = '0;
    case (reg_sel)
      4'h0:    rdata = {24'b0, rx_buf};
      4'h4:    rdata = {28'b0, rx_framing, rx_overrun, rx_valid, !tx_full};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in every clocked block so all registers update together.
    if (!resetn) begin
      bus_ack  <= 1'b0;
      bus_data <= '0;
    end else begin
      bus_ack  <= cs;
      bus_data <= rd ? rdata : '0;
    end
  end

  // Holding register drains into the shifter from IDLE, or straight from the
  // last STOP cycle so back-to-back bytes leave no idle gap.
  assign tx_load = tx_full &&
                   ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && (tx_cnt == '0)));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_full  <= 1'b0;
      uart_txd <= 1'b1;
    end else if (tx_load) begin
      tx_full  <= 1'b0;
      tx_state <= ST_START;
      tx_cnt   <= BIT_LAST;
      uart_txd <= 1'b0;
    end else begin
      if (tx_wr && !tx_full) tx_full <= 1'b1;
      case (tx_state)
        ST_START: begin
          if (tx_cnt == '0) begin
            tx_state <= ST_DATA;
            tx_cnt   <= BIT_LAST;
            tx_bit   <= '0;
            uart_txd <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_bit == 3'd7) begin
              tx_state <= ST_STOP;
              uart_txd <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              uart_txd <= tx_shift[tx_bit + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_cnt == '0) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= BIT_LAST;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: uart_txd <= 1'b1;
      endcase
    end
  end

  // Stop-bit decisions; a data read or intack in the same cycle frees the
  // buffer so an arriving byte is stored rather than flagged as overrun.
  assign rx_sample  = (rx_state == ST_STOP) && (rx_cnt == '0);
  assign rx_clr     = data_rd_clr || (irq && intack);
  assign rx_busy    = rx_valid && !rx_clr;
  assign rx_store   = rx_sample && rx_s2 && !rx_busy;
  assign rx_ovr_set = rx_sample && rx_s2 && rx_busy;
  assign rx_fe_set  = rx_sample && !rx_s2;
  assign irq_set    = rx_store && (rx_shift == 8'h03);
  assign irq_clr    = irq_wr_clr || (irq && intack);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_s1   <= uart_rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= ST_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        ST_START: begin
          if (rx_cnt == '0) begin
            rx_cnt <= BIT_LAST;
            rx_bit <= '0;
            rx_state <= rx_s2 ? ST_IDLE : ST_DATA;  // high at mid-start: glitch
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == '0) begin
            rx_cnt <= BIT_LAST;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= BIT_LAST;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: datapath bytes carry no reset; they are only meaningful behind flags that are reset.
  always_ff @(posedge clk) begin
    if (tx_wr && !tx_full)                    tx_hold  <= bus_wr_val[7:0];
    if (tx_load)                              tx_shift <= tx_hold;
    if ((rx_state == ST_DATA) && (rx_cnt == '0)) rx_shift <= {rx_s2, rx_shift[7:1]};
    if (rx_store)                             rx_buf   <= rx_shift;
  end

  // Status flags and interrupt: a set always beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_framing <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (rx_store)        rx_valid <= 1'b1;
      else if (rx_clr)     rx_valid <= 1'b0;

      if (rx_ovr_set)       rx_overrun <= 1'b1;
      else if (stat_rd_clr) rx_overrun <= 1'b0;

      if (rx_fe_set)        rx_framing <= 1'b1;
      else if (stat_rd_clr) rx_framing <= 1'b0;

      if (irq_set)      irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

endmodule
